axi_lite_bus_arbiter: RTL and testbench
=======================================

Name: axi_lite_bus_arbiter

Overview:
- Shares the MCU's single 32-bit AXI4-Lite master port between two requesters: instruction fetch (requester 0) and load/store unit (requester 1).
- Requesters use a simple REQ/ACK interface. The block arbitrates round-robin and sequences one complete AXI-Lite transaction at a time (AR/R for reads, AW+W/B for writes).
- It sits between the RV32I core and the interconnect that feeds internal memory and the UART.

Parameters:
AXI_AWIDTH, 32, address width
AXI_DWIDTH, 32, data width; strobe width = AXI_DWIDTH/8

Ports:
CLK  input  1  single clock, rising edge
NRST  input  1  reset, synchronous, active-low
REQ  input  2  per-requester request; bit i = requester i
WE  input  2  per-requester write enable (1 = write)
ADDR  input  2*AXI_AWIDTH  requester i at slice [i*AW +: AW]
WDATA  input  2*AXI_DWIDTH  requester i at slice [i*DW +: DW]
WSTRB  input  2*AXI_DWIDTH/8  per-requester byte strobes
ACK  output  2  one-cycle completion pulse to the served requester
RDATA  output  AXI_DWIDTH  read data, valid when ACK pulses on a read
ERR  output  1  valid with ACK; 1 when RESP[1]=1 (SLVERR/DECERR)
M_AWVALID / M_AWREADY  output / input  1  AW handshake
M_AWADDR  output  AXI_AWIDTH  write address
M_WVALID / M_WREADY  output / input  1  W handshake
M_WDATA  output  AXI_DWIDTH  write data
M_WSTRB  output  AXI_DWIDTH/8  write strobes
M_BVALID / M_BREADY  input / output  1  B handshake
M_BRESP  input  2  write response
M_ARVALID / M_ARREADY  output / input  1  AR handshake
M_ARADDR  output  AXI_AWIDTH  read address
M_RVALID / M_RREADY  input / output  1  R handshake
M_RDATA  input  AXI_DWIDTH  read data
M_RRESP  input  2  read response

Behaviour:
- Reset (NRST=0 at a clock edge):
  - State goes to IDLE.
  - All M_*VALID, M_BREADY, M_RREADY, ACK, ERR are 0; RDATA = 0; addr/data registers are 0.
  - The round-robin pointer is reset so that requester 0 is favoured.
  - Reset mid-transaction abandons the transaction immediately; no ACK is issued.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP.
- IDLE:
  - Arbitrates only when ACK==2'b00, which gives one dead cycle after each ACK so the requester can drop REQ.
  - If exactly one REQ bit is set, that requester wins.
  - If both are set, the requester not served last wins, and the pointer updates to point away from the winner.
  - On grant, latch the winner's ADDR, WDATA, WSTRB, WE and index. Next state is RD_ADDR (WE=0) or WR_ADDR_DATA (WE=1).
- RD_ADDR: M_ARVALID=1 with the latched address. On M_ARREADY, go to RD_DATA.
- RD_DATA:
  - M_RREADY=1.
  - On M_RVALID: register RDATA=M_RDATA and ERR=M_RRESP[1], pulse ACK[idx] for the next cycle, go to IDLE.
- WR_ADDR_DATA:
  - M_AWVALID and M_WVALID assert together.
  - Each drops independently after its own handshake; sticky done flags track this.
  - Move to WR_RESP when both handshakes are done, including the same-cycle case.
- WR_RESP:
  - M_BREADY=1.
  - On M_BVALID: ERR=M_BRESP[1], pulse ACK[idx], go to IDLE. RDATA holds its previous value.
- VALID stability: once asserted, a VALID and its payload stay stable until the handshake completes (AXI rule).
- Requester contract:
  - Hold REQ and its payload until ACK.
  - Dropping REQ mid-transaction has no effect; the transaction completes and ACK still pulses.
- Latency with an always-ready slave:
  - Read: REQ at cycle 0 → ARVALID at cycle 1 → RREADY/RVALID at cycle 2 → ACK at cycle 3.
  - Write: ACK at cycle 3 likewise.
- No outstanding-transaction pipelining and no timeout; a stalled slave stalls the arbiter indefinitely.

Decomposition:
- Package riscv_bus_pkg holds:
  - the state enum arb_state_t;
  - AXI response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - requester index constants REQ_IFU=0, REQ_LSU=1.
- One sub-module, rr_arbiter2: 2-way round-robin grant with a pointer register and CLK/NRST. It outputs a one-hot grant when enabled.

Test Plan:
- Single read: REQ=01, ADDR0=0x0000_0040, slave returns 0xDEAD_BEEF/OKAY with ready=1 → ARADDR=0x40, ACK=01 at cycle 3, RDATA=0xDEADBEEF, ERR=0.
- Single write: REQ=10, WE=10, ADDR1=0x1000_0000 (UART), WDATA1=0x41, WSTRB1=0x1 → AW/W carry these values, BRESP=OKAY, ACK=10, ERR=0.
- Contention: REQ=11 held continuously → grants alternate 0,1,0,1 over 4 transactions; ACK never has both bits set.
- Backpressure and split handshakes:
  - AWREADY at cycle 2 and WREADY at cycle 5 → AWVALID drops after cycle 2, WVALID holds to cycle 5, BREADY from cycle 6.
  - ARREADY low for 4 cycles → ARVALID and ARADDR stay stable throughout.
- Error response: read returns RRESP=SLVERR, then write returns BRESP=DECERR → ERR=1 with each ACK.
- Reset mid-write: NRST=0 during WR_RESP → next cycle all VALIDs, READYs and ACK are 0; state IDLE; after release, REQ=11 grants requester 0.

Source files
------------

// File: rtl/riscv_bus_pkg.sv
// Shared types and constants for the core's AXI4-Lite bus arbiter.
package riscv_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int REQ_IFU = 0;
    localparam int REQ_LSU = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant while enabled, pointer moves
// away from whichever requester was just granted.
module rr_arbiter2
    import riscv_bus_pkg::*;
(
    input  logic       CLK,
    input  logic       NRST,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // ptr_q = 1 favours the LSU when both request
    logic ptr_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            ptr_q <= 1'b0;
        end else if (|gnt_o) begin
            ptr_q <= gnt_o[REQ_IFU];
        end
    end

endmodule

// File: rtl/axi_lite_bus_arbiter.sv
// Shares one AXI4-Lite master port between instruction fetch and the LSU,
// running one complete read or write transaction at a time.
module axi_lite_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                           CLK,
    input  logic                           NRST,
    input  logic [1:0]                     REQ,
    input  logic [1:0]                     WE,
    input  logic [2*AXI_AWIDTH-1:0]        ADDR,
    input  logic [2*AXI_DWIDTH-1:0]        WDATA,
    input  logic [2*(AXI_DWIDTH/8)-1:0]    WSTRB,
    output logic [1:0]                     ACK,
    output logic [AXI_DWIDTH-1:0]          RDATA,
    output logic                           ERR,
    output logic                           M_AWVALID,
    input  logic                           M_AWREADY,
    output logic [AXI_AWIDTH-1:0]          M_AWADDR,
    output logic                           M_WVALID,
    input  logic                           M_WREADY,
    output logic [AXI_DWIDTH-1:0]          M_WDATA,
    output logic [AXI_DWIDTH/8-1:0]        M_WSTRB,
    input  logic                           M_BVALID,
    output logic                           M_BREADY,
    input  logic [1:0]                     M_BRESP,
    output logic                           M_ARVALID,
    input  logic                           M_ARREADY,
    output logic [AXI_AWIDTH-1:0]          M_ARADDR,
    input  logic                           M_RVALID,
    output logic                           M_RREADY,
    input  logic [AXI_DWIDTH-1:0]          M_RDATA,
    input  logic [1:0]                     M_RRESP
);

    localparam int SW = AXI_DWIDTH / 8;

    arb_state_t              state_q;
    logic                    idx_q;
    logic [AXI_AWIDTH-1:0]   addr_q;
    logic [AXI_DWIDTH-1:0]   wdata_q;
    logic [SW-1:0]           wstrb_q;
    logic                    arvalid_q, rready_q;
    logic                    awvalid_q, wvalid_q, bready_q;
    logic                    aw_done_q, w_done_q;
    logic                    aw_done_d, w_done_d;
    logic [1:0]              ack_q;
    logic [AXI_DWIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic                    arb_en;
    logic [1:0]              gnt;
    logic                    win;
    logic                    win_we;
    logic [AXI_AWIDTH-1:0]   win_addr;
    logic [AXI_DWIDTH-1:0]   win_wdata;
    logic [SW-1:0]           win_wstrb;

    // Holding off while ACK is high gives the requester a cycle to drop REQ
    assign arb_en = (state_q == IDLE) && (ack_q == 2'b00);

    rr_arbiter2 u_rr (
        .CLK   (CLK),
        .NRST  (NRST),
        .en_i  (arb_en),
        .req_i (REQ),
        .gnt_o (gnt)
    );

    assign win       = gnt[REQ_LSU];
    assign win_we    = WE[win];
    assign win_addr  = win ? ADDR[2*AXI_AWIDTH-1:AXI_AWIDTH] : ADDR[AXI_AWIDTH-1:0];
    assign win_wdata = win ? WDATA[2*AXI_DWIDTH-1:AXI_DWIDTH] : WDATA[AXI_DWIDTH-1:0];
    assign win_wstrb = win ? WSTRB[2*SW-1:SW] : WSTRB[SW-1:0];

    // AW and W complete independently; the done flags remember each one
    assign aw_done_d = aw_done_q | (awvalid_q & M_AWREADY);
    assign w_done_d  = w_done_q  | (wvalid_q  & M_WREADY);

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q   <= IDLE;
            idx_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ack_q     <= 2'b00;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        idx_q     <= win;
                        addr_q    <= win_addr;
                        wdata_q   <= win_wdata;
                        wstrb_q   <= win_wstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (win_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (M_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_RVALID) begin
                        rready_q <= 1'b0;
                        rdata_q  <= M_RDATA;
                        err_q    <= M_RRESP[1];
                        ack_q    <= idx_q ? 2'b10 : 2'b01;
                        state_q  <= IDLE;
                    end
                end
                WR_ADDR_DATA: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d) awvalid_q <= 1'b0;
                    if (w_done_d)  wvalid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_BVALID) begin
                        bready_q <= 1'b0;
                        err_q    <= M_BRESP[1];
                        ack_q    <= idx_q ? 2'b10 : 2'b01;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ACK       = ack_q;
    assign RDATA     = rdata_q;
    assign ERR       = err_q;
    assign M_ARVALID = arvalid_q;
    assign M_ARADDR  = addr_q;
    assign M_RREADY  = rready_q;
    assign M_AWVALID = awvalid_q;
    assign M_AWADDR  = addr_q;
    assign M_WVALID  = wvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_BREADY  = bready_q;

endmodule

// File: tb/tb_axi_lite_bus_arbiter.sv
// Directed bench for axi_lite_bus_arbiter with a transaction-level reference
// model compared against the DUT on every falling edge.
module tb_axi_lite_bus_arbiter;
    import riscv_bus_pkg::*;

    logic        CLK = 1'b0;
    logic        NRST;
    logic [1:0]  REQ, WE;
    logic [63:0] ADDR, WDATA;
    logic [7:0]  WSTRB;
    logic [1:0]  ACK;
    logic [31:0] RDATA;
    logic        ERR;
    logic        M_AWVALID, M_AWREADY;
    logic [31:0] M_AWADDR;
    logic        M_WVALID, M_WREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_BVALID, M_BREADY;
    logic [1:0]  M_BRESP;
    logic        M_ARVALID, M_ARREADY;
    logic [31:0] M_ARADDR;
    logic        M_RVALID, M_RREADY;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;

    axi_lite_bus_arbiter #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
        .CLK(CLK), .NRST(NRST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .WSTRB(WSTRB), .ACK(ACK), .RDATA(RDATA), .ERR(ERR),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWADDR(M_AWADDR),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Reference model: one transaction in flight, tracked by which AXI phases
    // have completed; arbitration follows the "not served last" rule.
    logic        m_on = 1'b0;
    logic        m_inflight, m_we, m_idx, m_last, m_prev;
    logic        m_ar_done, m_aw_done, m_w_done;
    logic        m_ack, m_ack_idx, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    always @(posedge CLK) begin
        if (!NRST) begin
            m_on       = 1'b1;
            m_inflight = 1'b0;
            m_ack      = 1'b0;
            m_ack_idx  = 1'b0;
            m_last     = 1'b1;
            m_rdata    = 32'h0;
            m_err      = 1'b0;
            m_we       = 1'b0;
            m_ar_done  = 1'b0;
            m_aw_done  = 1'b0;
            m_w_done   = 1'b0;
        end else if (m_on) begin
            m_prev = m_ack;
            m_ack  = 1'b0;
            if (m_inflight) begin
                if (M_ARVALID && M_ARREADY) m_ar_done = 1'b1;
                if (M_AWVALID && M_AWREADY) m_aw_done = 1'b1;
                if (M_WVALID && M_WREADY)   m_w_done  = 1'b1;
                if (!m_we && M_RVALID && M_RREADY) begin
                    m_rdata = M_RDATA;
                    m_err = M_RRESP[1];
                    m_ack = 1'b1;
                    m_ack_idx = m_idx;
                    m_inflight = 1'b0;
                end
                if (m_we && M_BVALID && M_BREADY) begin
                    m_err = M_BRESP[1];
                    m_ack = 1'b1;
                    m_ack_idx = m_idx;
                    m_inflight = 1'b0;
                end
            end else if (!m_prev && REQ != 2'b00) begin
                m_idx      = (REQ == 2'b11) ? ~m_last : REQ[1];
                m_we       = WE[m_idx];
                m_addr     = m_idx ? ADDR[63:32]  : ADDR[31:0];
                m_wdata    = m_idx ? WDATA[63:32] : WDATA[31:0];
                m_wstrb    = m_idx ? WSTRB[7:4]   : WSTRB[3:0];
                m_last     = m_idx;
                m_inflight = 1'b1;
                m_ar_done  = 1'b0;
                m_aw_done  = 1'b0;
                m_w_done   = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_on) begin
            chk("ack", 32'(ACK), m_ack ? (m_ack_idx ? 32'd2 : 32'd1) : 32'd0);
            chk("rdata_hold", RDATA, m_rdata);
            if (m_ack) chk("err", 32'(ERR), 32'(m_err));
            chk("arvalid", 32'(M_ARVALID), 32'(m_inflight && !m_we && !m_ar_done));
            chk("rready",  32'(M_RREADY),  32'(m_inflight && !m_we && m_ar_done));
            chk("awvalid", 32'(M_AWVALID), 32'(m_inflight && m_we && !m_aw_done));
            chk("wvalid",  32'(M_WVALID),  32'(m_inflight && m_we && !m_w_done));
            chk("bready",  32'(M_BREADY),  32'(m_inflight && m_we && m_aw_done && m_w_done));
            if (M_ARVALID) chk("araddr", M_ARADDR, m_addr);
            if (M_AWVALID) chk("awaddr", M_AWADDR, m_addr);
            if (M_WVALID) begin
                chk("wdata", M_WDATA, m_wdata);
                chk("wstrb", 32'(M_WSTRB), 32'(m_wstrb));
            end
        end
    end

    task automatic slave(input logic arr, input logic rv, input logic [31:0] rd,
                         input logic [1:0] rr, input logic awr, input logic wr,
                         input logic bv, input logic [1:0] br);
        M_ARREADY = arr; M_RVALID = rv; M_RDATA = rd; M_RRESP = rr;
        M_AWREADY = awr; M_WREADY = wr; M_BVALID = bv; M_BRESP = br;
    endtask

    logic [1:0] seq [4];
    logic [1:0] exp_seq [4];
    int got;

    initial begin
        NRST = 1'b0; REQ = 2'b00; WE = 2'b00; ADDR = '0; WDATA = '0; WSTRB = '0;
        slave(1'b0, 1'b0, 32'h0, RESP_OKAY, 1'b0, 1'b0, 1'b0, RESP_OKAY);
        step(3);
        chk("rst_ack", 32'(ACK), 32'd0);
        chk("rst_valids", 32'({M_ARVALID, M_AWVALID, M_WVALID}), 32'd0);
        chk("rst_readies", 32'({M_RREADY, M_BREADY}), 32'd0);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_err", 32'(ERR), 32'd0);
        NRST = 1'b1;
        step(1);

        // Single read from requester 0, always-ready slave
        slave(1'b1, 1'b1, 32'hDEAD_BEEF, RESP_OKAY, 1'b1, 1'b1, 1'b1, RESP_OKAY);
        REQ = 2'b01; WE = 2'b00; ADDR = {32'h0, 32'h0000_0040};
        step(1);
        chk("rd_arvalid_c1", 32'(M_ARVALID), 32'd1);
        chk("rd_araddr_c1", M_ARADDR, 32'h0000_0040);
        step(1);
        chk("rd_rready_c2", 32'(M_RREADY), 32'd1);
        step(1);
        chk("rd_ack_c3", 32'(ACK), 32'd1);
        chk("rd_rdata_c3", RDATA, 32'hDEAD_BEEF);
        chk("rd_err_c3", 32'(ERR), 32'd0);
        REQ = 2'b00;
        step(2);

        // Single write from requester 1 to the UART
        REQ = 2'b10; WE = 2'b10;
        ADDR = {32'h1000_0000, 32'h0}; WDATA = {32'h0000_0041, 32'h0}; WSTRB = {4'h1, 4'h0};
        step(1);
        chk("wr_awvalid_c1", 32'({M_AWVALID, M_WVALID}), 32'd3);
        chk("wr_awaddr_c1", M_AWADDR, 32'h1000_0000);
        chk("wr_wdata_c1", M_WDATA, 32'h0000_0041);
        chk("wr_wstrb_c1", 32'(M_WSTRB), 32'h1);
        step(1);
        chk("wr_bready_c2", 32'(M_BREADY), 32'd1);
        step(1);
        chk("wr_ack_c3", 32'(ACK), 32'd2);
        chk("wr_err_c3", 32'(ERR), 32'd0);
        chk("wr_rdata_kept", RDATA, 32'hDEAD_BEEF);
        REQ = 2'b00; WE = 2'b00;
        step(2);

        // Contention: both requesting continuously
        slave(1'b1, 1'b1, 32'h1111_0000, RESP_OKAY, 1'b1, 1'b1, 1'b1, RESP_OKAY);
        REQ = 2'b11; WE = 2'b00; ADDR = {32'h0000_0200, 32'h0000_0100};
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            step(1);
            if (ACK != 2'b00) begin
                seq[got] = ACK;
                got++;
            end
        end
        REQ = 2'b00;
        chk("rr_ack_count", 32'(got), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got) chk("rr_order", 32'(seq[i]), 32'(exp_seq[i]));
        step(2);

        // Write with AWREADY at cycle 2 and WREADY at cycle 5
        slave(1'b1, 1'b1, 32'h0, RESP_OKAY, 1'b0, 1'b0, 1'b1, RESP_OKAY);
        REQ = 2'b01; WE = 2'b01;
        ADDR = {32'h0, 32'h0000_2000}; WDATA = {32'h0, 32'h1234_5678}; WSTRB = {4'h0, 4'hF};
        step(1);
        chk("split_both_c1", 32'({M_AWVALID, M_WVALID}), 32'd3);
        step(1);
        M_AWREADY = 1'b1;
        step(1);
        M_AWREADY = 1'b0;
        chk("split_aw_drop_c3", 32'(M_AWVALID), 32'd0);
        chk("split_w_hold_c3", 32'(M_WVALID), 32'd1);
        step(2);
        chk("split_w_hold_c5", 32'({M_WVALID, M_BREADY}), 32'd2);
        chk("split_wdata_c5", M_WDATA, 32'h1234_5678);
        M_WREADY = 1'b1;
        step(1);
        M_WREADY = 1'b0;
        chk("split_w_drop_c6", 32'(M_WVALID), 32'd0);
        chk("split_bready_c6", 32'(M_BREADY), 32'd1);
        step(1);
        chk("split_ack_c7", 32'(ACK), 32'd1);
        REQ = 2'b00; WE = 2'b00;
        step(2);

        // Read stalled by ARREADY for four cycles, answered with SLVERR
        slave(1'b0, 1'b1, 32'hCAFE_F00D, RESP_SLVERR, 1'b1, 1'b1, 1'b1, RESP_OKAY);
        REQ = 2'b10; WE = 2'b00; ADDR = {32'h0000_3000, 32'h0};
        for (int c = 1; c <= 4; c++) begin
            step(1);
            chk("stall_arvalid", 32'(M_ARVALID), 32'd1);
            chk("stall_araddr", M_ARADDR, 32'h0000_3000);
        end
        step(1);
        chk("stall_arvalid_c5", 32'(M_ARVALID), 32'd1);
        M_ARREADY = 1'b1;
        step(1);
        chk("stall_rready_c6", 32'({M_ARVALID, M_RREADY}), 32'd1);
        step(1);
        chk("slverr_ack", 32'(ACK), 32'd2);
        chk("slverr_err", 32'(ERR), 32'd1);
        chk("slverr_rdata", RDATA, 32'hCAFE_F00D);
        REQ = 2'b00;
        step(2);

        // Write answered with DECERR
        slave(1'b1, 1'b1, 32'h0, RESP_OKAY, 1'b1, 1'b1, 1'b1, RESP_DECERR);
        REQ = 2'b01; WE = 2'b01;
        ADDR = {32'h0, 32'h0000_0044}; WDATA = {32'h0, 32'h0000_0055}; WSTRB = {4'h0, 4'hF};
        step(3);
        chk("decerr_ack", 32'(ACK), 32'd1);
        chk("decerr_err", 32'(ERR), 32'd1);
        chk("decerr_rdata_kept", RDATA, 32'hCAFE_F00D);
        REQ = 2'b00; WE = 2'b00; M_BRESP = RESP_OKAY;
        step(2);

        // Reset while waiting for the write response
        slave(1'b1, 1'b1, 32'h7777_0000, RESP_OKAY, 1'b1, 1'b1, 1'b0, RESP_OKAY);
        REQ = 2'b10; WE = 2'b10;
        ADDR = {32'h1000_0004, 32'h0}; WDATA = {32'h0000_0042, 32'h0}; WSTRB = {4'h1, 4'h0};
        step(2);
        chk("mid_bready_c2", 32'(M_BREADY), 32'd1);
        NRST = 1'b0;
        M_BVALID = 1'b1;
        step(1);
        chk("mid_ack", 32'(ACK), 32'd0);
        chk("mid_valids", 32'({M_ARVALID, M_AWVALID, M_WVALID}), 32'd0);
        chk("mid_readies", 32'({M_RREADY, M_BREADY}), 32'd0);
        chk("mid_rdata", RDATA, 32'h0);
        chk("mid_err", 32'(ERR), 32'd0);
        NRST = 1'b1;
        REQ = 2'b11; WE = 2'b00; ADDR = {32'h0000_0300, 32'h0000_0080};
        step(1);
        chk("post_rst_grant", 32'(M_ARVALID), 32'd1);
        chk("post_rst_addr", M_ARADDR, 32'h0000_0080);
        step(2);
        chk("post_rst_ack", 32'(ACK), 32'd1);
        REQ = 2'b00;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
